// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command parser.
package serial_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_EMIT
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_BAD_CSUM = 2'd2;
  localparam logic [1:0] ERR_TRUNC    = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;
  localparam int         DEFAULT_MAX_LEN   = 16;

  // States in which a frame is still being received and can be cut short.
  function automatic logic isReceiving(state_t s);
    return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/serial_cmd_buf.sv
// Payload buffer: synchronous write, asynchronous read, one byte per entry.
module serial_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [7:0]       wrData,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [7:0]       rdData
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per accepted PAYLOAD byte.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/serial_cmd_parser.sv
// Framed write-command decoder: SYNC, ADDR, LEN, PAYLOAD, XOR CSUM, then
// replays the buffered payload as back-to-back register writes.
module serial_cmd_parser
  import serial_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN   = DEFAULT_MAX_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  input  logic       rx_endofpacket,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     stateReg, stateNext;
  logic [7:0] baseReg, baseNext;
  logic [7:0] lenReg, lenNext;
  logic [7:0] idxReg, idxNext;
  logic [7:0] csumReg, csumNext;

  logic       wrEnReg, wrEnNext;
  logic [7:0] wrAddrReg, wrAddrNext;
  logic [7:0] wrDataReg, wrDataNext;
  logic       frameOkReg, frameOkNext;
  logic       frameErrReg, frameErrNext;
  logic [1:0] errCodeReg, errCodeNext;

  logic             bufWe;
  logic [IDX_W-1:0] bufRdIdx;
  logic [7:0]       bufRdData;

  // In CSUM the first write (entry 0) is prepared; EMIT reads entry idx.
  assign bufRdIdx = (stateReg == ST_EMIT) ? idxReg[IDX_W-1:0] : '0;

  serial_cmd_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk    (clk),
    .wrEn   (bufWe),
    .wrIdx  (idxReg[IDX_W-1:0]),
    .wrData (rx_data),
    .rdIdx  (bufRdIdx),
    .rdData (bufRdData)
  );

  // Frame state machine plus next values of the registered outputs.
  // Write k of a frame is computed one cycle early so it appears registered:
  // write 0 from CSUM, writes 1..len-1 from EMIT with idx=k; idx==len ends EMIT.
  always_comb begin
    stateNext    = stateReg;
    baseNext     = baseReg;
    lenNext      = lenReg;
    idxNext      = idxReg;
    csumNext     = csumReg;
    wrEnNext     = 1'b0;
    wrAddrNext   = 8'h00;
    wrDataNext   = 8'h00;
    frameOkNext  = 1'b0;
    frameErrNext = 1'b0;
    errCodeNext  = errCodeReg;
    bufWe        = 1'b0;

    case (stateReg)
      ST_IDLE: begin
        if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
          stateNext = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_data_ready) begin
          baseNext  = rx_data;
          csumNext  = rx_data;
          stateNext = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_data_ready) begin
          if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
            frameErrNext = 1'b1;
            errCodeNext  = ERR_BAD_LEN;
            stateNext    = ST_IDLE;
          end else begin
            lenNext   = rx_data;
            csumNext  = csumReg ^ rx_data;
            idxNext   = 8'h00;
            stateNext = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_data_ready) begin
          bufWe    = 1'b1;
          csumNext = csumReg ^ rx_data;
          idxNext  = idxReg + 8'd1;
          if (idxReg == lenReg - 8'd1) begin
            stateNext = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_data_ready) begin
          if (rx_data == csumReg) begin
            wrEnNext    = 1'b1;
            wrAddrNext  = baseReg;
            wrDataNext  = bufRdData;
            frameOkNext = (lenReg == 8'd1);
            idxNext     = 8'd1;
            stateNext   = ST_EMIT;
          end else begin
            frameErrNext = 1'b1;
            errCodeNext  = ERR_BAD_CSUM;
            stateNext    = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (idxReg == lenReg) begin
          stateNext = ST_IDLE;
        end else begin
          wrEnNext    = 1'b1;
          wrAddrNext  = baseReg + idxReg;
          wrDataNext  = bufRdData;
          frameOkNext = (idxReg == lenReg - 8'd1);
          idxNext     = idxReg + 8'd1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    // End of packet while still receiving; judged after the byte in the
    // same cycle, so a completing checksum byte is not treated as truncated.
    if (rx_endofpacket && isReceiving(stateReg) && isReceiving(stateNext)) begin
      stateNext    = ST_IDLE;
      bufWe        = 1'b0;
      frameErrNext = 1'b1;
      errCodeNext  = ERR_TRUNC;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= ST_IDLE;
      baseReg     <= 8'h00;
      lenReg      <= 8'h00;
      idxReg      <= 8'h00;
      csumReg     <= 8'h00;
      wrEnReg     <= 1'b0;
      wrAddrReg   <= 8'h00;
      wrDataReg   <= 8'h00;
      frameOkReg  <= 1'b0;
      frameErrReg <= 1'b0;
      errCodeReg  <= ERR_NONE;
    end else begin
      stateReg    <= stateNext;
      baseReg     <= baseNext;
      lenReg      <= lenNext;
      idxReg      <= idxNext;
      csumReg     <= csumNext;
      wrEnReg     <= wrEnNext;
      wrAddrReg   <= wrAddrNext;
      wrDataReg   <= wrDataNext;
      frameOkReg  <= frameOkNext;
      frameErrReg <= frameErrNext;
      errCodeReg  <= errCodeNext;
    end
  end

  assign wr_en     = wrEnReg;
  assign wr_addr   = wrAddrReg;
  assign wr_data   = wrDataReg;
  assign frame_ok  = frameOkReg;
  assign frame_err = frameErrReg;
  assign err_code  = errCodeReg;
  assign busy      = (stateReg != ST_IDLE);

endmodule

// File: tb/tb_serial_cmd_parser.sv
// Directed bench for serial_cmd_parser with hand-computed frames.
module tb_serial_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_ready = 1'b0;
  logic       rx_endofpacket = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checkCount = 0;
  int passCount  = 0;
  int wrSeen     = 0;
  int errSeen    = 0;
  int okSeen     = 0;
  int wrMark, errMark, okMark;

  serial_cmd_parser dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_endofpacket (rx_endofpacket),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .err_code       (err_code),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, used to prove absence of activity.
  always @(negedge clk) begin
    if (wr_en)     wrSeen  <= wrSeen + 1;
    if (frame_err) errSeen <= errSeen + 1;
    if (frame_ok)  okSeen  <= okSeen + 1;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Present one byte for exactly one rising edge; returns 1 ns after that edge.
  task automatic sendByte(input logic [7:0] b, input logic eop);
    rx_data        = b;
    rx_data_ready  = 1'b1;
    rx_endofpacket = eop;
    @(posedge clk);
    #1;
    rx_data        = 8'h00;
    rx_data_ready  = 1'b0;
    rx_endofpacket = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) sendByte(bytes[i], 1'b0);
  endtask

  task automatic expectWrite(input string tag, input logic [7:0] a, input logic [7:0] d, input logic ok);
    @(negedge clk);
    checkEq({tag, " wr_en"}, wr_en, 1);
    checkEq({tag, " wr_addr"}, wr_addr, a);
    checkEq({tag, " wr_data"}, wr_data, d);
    checkEq({tag, " frame_ok"}, frame_ok, ok);
    checkEq({tag, " frame_err"}, frame_err, 0);
    checkEq({tag, " busy"}, busy, 1);
    $display("write %s addr=%02h data=%02h ok=%0b", tag, wr_addr, wr_data, frame_ok);
  endtask

  task automatic expectQuiet(input string tag);
    @(negedge clk);
    checkEq({tag, " wr_en"}, wr_en, 0);
    checkEq({tag, " wr_addr"}, wr_addr, 0);
    checkEq({tag, " wr_data"}, wr_data, 0);
    checkEq({tag, " frame_ok"}, frame_ok, 0);
    checkEq({tag, " busy"}, busy, 0);
  endtask

  task automatic expectErr(input string tag, input logic [1:0] code);
    @(negedge clk);
    checkEq({tag, " frame_err"}, frame_err, 1);
    checkEq({tag, " err_code"}, err_code, code);
    checkEq({tag, " wr_en"}, wr_en, 0);
    $display("error %s code=%0d", tag, err_code);
    @(negedge clk);
    checkEq({tag, " frame_err pulse"}, frame_err, 0);
    checkEq({tag, " err_code hold"}, err_code, code);
    checkEq({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] big[$];

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkEq("reset wr_en", wr_en, 0);
    checkEq("reset frame_err", frame_err, 0);
    checkEq("reset err_code", err_code, 0);
    checkEq("reset busy", busy, 0);
    $display("reset done");
    @(posedge clk); #1;

    // Good frame.
    sendFrame('{8'hAA, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    expectWrite("good0", 8'h10, 8'h11, 1'b0);
    expectWrite("good1", 8'h11, 8'h22, 1'b0);
    expectWrite("good2", 8'h12, 8'h33, 1'b1);
    expectQuiet("good end");
    @(posedge clk); #1;

    // Address wrap.
    sendFrame('{8'hAA, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFD});
    expectWrite("wrap0", 8'hFE, 8'h01, 1'b0);
    expectWrite("wrap1", 8'hFF, 8'h02, 1'b0);
    expectWrite("wrap2", 8'h00, 8'h03, 1'b1);
    expectQuiet("wrap end");
    @(posedge clk); #1;

    // Bad checksum.
    wrMark = wrSeen;
    sendFrame('{8'hAA, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14});
    expectErr("badcsum", 2'd2);
    checkEq("badcsum no writes", wrSeen - wrMark, 0);
    @(posedge clk); #1;

    // Bad length: zero, then above maximum, then stray bytes ignored.
    sendFrame('{8'hAA, 8'h10, 8'h00});
    expectErr("badlen0", 2'd1);
    @(posedge clk); #1;
    sendFrame('{8'hAA, 8'h10, 8'h11});
    expectErr("badlen17", 2'd1);
    @(posedge clk); #1;
    wrMark = wrSeen; errMark = errSeen;
    sendFrame('{8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    repeat (3) @(posedge clk); #1;
    checkEq("stray writes", wrSeen - wrMark, 0);
    checkEq("stray errors", errSeen - errMark, 0);
    checkEq("stray busy", busy, 0);

    // Truncation with leading garbage, then resync on a good frame.
    sendFrame('{8'h55, 8'h00, 8'hAA, 8'h10, 8'h03, 8'h11});
    rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    rx_endofpacket = 1'b0;
    expectErr("trunc", 2'd3);
    @(posedge clk); #1;
    sendFrame('{8'hAA, 8'h20, 8'h02, 8'h5A, 8'hA5, 8'hDD});
    expectWrite("resync0", 8'h20, 8'h5A, 1'b0);
    expectWrite("resync1", 8'h21, 8'hA5, 1'b1);
    expectQuiet("resync end");
    @(posedge clk); #1;

    // Checksum byte coinciding with end of packet still completes.
    errMark = errSeen;
    sendFrame('{8'hAA, 8'h30, 8'h01, 8'h77});
    sendByte(8'h46, 1'b1);
    expectWrite("csumeop", 8'h30, 8'h77, 1'b1);
    expectQuiet("csumeop end");
    @(posedge clk); #1;
    checkEq("csumeop no error", errSeen - errMark, 0);

    // Maximum length frame (16 bytes, data 1..16, checksum 40).
    big = '{8'hAA, 8'h40, 8'h10};
    for (int i = 1; i <= 16; i++) big.push_back(8'(i));
    big.push_back(8'h40);
    sendFrame(big);
    for (int i = 0; i < 16; i++) begin
      expectWrite($sformatf("max%0d", i), 8'(8'h40 + i), 8'(i + 1), (i == 15));
    end
    expectQuiet("max end");
    @(posedge clk); #1;

    // Reset mid-frame aborts the frame.
    wrMark = wrSeen; errMark = errSeen; okMark = okSeen;
    sendFrame('{8'hAA, 8'h10, 8'h03, 8'h11});
    checkEq("midframe busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkEq("post-reset busy", busy, 0);
    sendFrame('{8'h22, 8'h33, 8'h13});
    repeat (4) @(posedge clk); #1;
    checkEq("rst writes", wrSeen - wrMark, 0);
    checkEq("rst errors", errSeen - errMark, 0);
    checkEq("rst oks", okSeen - okMark, 0);
    expectQuiet("rst end");
    checkEq("rst err_code", err_code, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/serial_cmd_parser.md
# serial_cmd_parser

Byte-stream command decoder sitting directly downstream of the UART receiver. It consumes received bytes plus the end-of-packet pulse and recognises framed write commands: sync, base address, length, payload, XOR checksum. Payload is buffered, and only a frame whose checksum verifies is replayed as a burst of register-write strobes into the slave's register file. Malformed or truncated frames are discarded and reported with an error code.

## Interface
- SYNC_BYTE, 8'hAA, frame start marker.
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- clk  in  1  system clock, same domain as the UART receiver.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_data_ready=1.
- rx_data_ready  in  1  one-cycle strobe per received byte.
- rx_endofpacket  in  1  one-cycle strobe when the line goes idle after a burst.
- wr_en  out  1  register write strobe, one write per cycle.
- wr_addr  out  8  write address.
- wr_data  out  8  write data.
- frame_ok  out  1  one-cycle pulse, coincident with the last write of a good frame.
- frame_err  out  1  one-cycle pulse on a rejected frame.
- err_code  out  2  valid with frame_err: 1=BAD_LEN, 2=BAD_CSUM, 3=TRUNCATED; holds its last value otherwise.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, LEN, PAYLOAD, CSUM, EMIT.
- IDLE: a byte equal to SYNC_BYTE moves to ADDR; any other byte is silently dropped.
- ADDR: the byte is latched as base; csum_acc <= byte; next state LEN.
- LEN:
  - len=0 or len>MAX_LEN: frame_err with BAD_LEN, return to IDLE.
  - Otherwise latch len, csum_acc ^= byte, idx <= 0, next state PAYLOAD.
- PAYLOAD: buf[idx] <= byte, csum_acc ^= byte, idx++; when idx reaches len-1 on acceptance, next state CSUM.
- CSUM:
  - byte==csum_acc: go to EMIT with idx <= 0.
  - Mismatch: frame_err with BAD_CSUM, return to IDLE.
- EMIT:
  - Each cycle: wr_en=1, wr_addr=base+idx (8-bit, wraps 8'hFF->8'h00), wr_data=buf[idx], idx++.
  - After len writes, return to IDLE; frame_ok pulses with the final write.
- rx_endofpacket in ADDR, LEN, PAYLOAD or CSUM: frame_err with TRUNCATED, return to IDLE. In IDLE or EMIT it is ignored.
- rx_data_ready in EMIT: the byte is dropped. At bit rates of 115200 or slower, EMIT (≤MAX_LEN cycles) always completes long before the next byte arrives.
- rx_data_ready and rx_endofpacket in the same cycle: process the byte first. Truncation is judged on the resulting state, so a completing checksum byte is not truncated.
- rst: state=IDLE, idx=0, csum_acc=0, base=0, len=0. All outputs are 0 (err_code=0). Reset mid-frame or mid-EMIT aborts with no further writes and no pulses.

## Timing
- Each byte is accepted on the clk edge where rx_data_ready=1; the state update is visible the next cycle.
- Good frame: checksum byte accepted at edge T; first wr_en at T+1; writes at T+1..T+len, back to back; frame_ok at T+len; busy low from T+len+1.
- BAD_LEN / BAD_CSUM: frame_err and err_code registered, high for exactly one cycle, T+1 after the offending byte.
- TRUNCATED: frame_err high the cycle after rx_endofpacket.
- wr_en, wr_addr, wr_data, frame_ok, frame_err and err_code are all registered outputs; wr_addr/wr_data are 0 when wr_en=0.

## Structure
- Package serial_cmd_pkg holds:
  - the state enum,
  - err_code constants (ERR_NONE=0, ERR_BAD_LEN=1, ERR_BAD_CSUM=2, ERR_TRUNC=3),
  - the default SYNC_BYTE.
- One sub-module, serial_cmd_buf: an MAX_LEN x 8 register-file buffer with a synchronous write port and an asynchronous read port indexed by idx.

## Test plan
- Good frame: AA 10 03 11 22 33 13 -> writes (10,11),(11,22),(12,33) on three consecutive cycles; frame_ok on the third; no frame_err.
- Address wrap: AA FE 03 01 02 03 FD -> writes at FE, FF, 00 with data 01, 02, 03; frame_ok.
- Bad checksum: AA 10 03 11 22 33 14 -> no wr_en; frame_err with err_code=2 one cycle after the last byte.
- Bad length: AA 10 00 -> frame_err with err_code=1. AA 10 11 (len 17 > MAX_LEN 16) -> err_code=1. Following bytes are ignored until the next AA.
- Truncation and resync: 55 00 AA 10 03 11 then rx_endofpacket -> frame_err with err_code=3. A following good frame decodes correctly.
- Reset mid-frame: AA 10 03 11, then rst for 1 cycle, then 22 33 13 -> no writes, busy=0, all outputs 0.
